// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU write-back stage: flag bit positions,
// condition codes and ALU op codes.
package alu_wb_stage_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned COND_W = 4;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_S = 3;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 4'b0000,
        COND_EQ = 4'b0001,
        COND_NE = 4'b0010,
        COND_LT = 4'b0011,
        COND_GE = 4'b0100,
        COND_CS = 4'b0101,
        COND_CC = 4'b0110,
        COND_MI = 4'b0111,
        COND_PL = 4'b1000,
        COND_VS = 4'b1001,
        COND_VC = 4'b1010,
        COND_NV = 4'b1011
    } cond_e;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;
    localparam logic [OP_W-1:0] OP_MOD = 4'd4;

endpackage

// File: rtl/alu_wb_stage_cond_check.sv
// Combinational evaluation of an execution condition code against a flag set.
module cond_check
    import alu_wb_stage_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              pass
);

    logic v;
    logic c;
    logic z;
    logic s;

    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign s = flags[FLAG_S];

    // Codes above VC, including the NV encoding itself, never execute.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_LT: pass = s ^ v;
            COND_GE: pass = !(s ^ v);
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = s;
            COND_PL: pass = !s;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: 2-entry in-order skid buffer toward the register file,
// with condition evaluation and the committed flag register.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  resultado,
    input  logic [FLAG_W-1:0] flagsResult,
    input  logic [OP_W-1:0]   operacion,
    input  logic [RADDR-1:0]  rd,
    input  logic              set_flags,
    input  logic [COND_W-1:0] cond,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_result,
    output logic [RADDR-1:0]  out_rd,
    output logic [OP_W-1:0]   out_op,
    output logic              out_we,
    output logic [FLAG_W-1:0] flags_q
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RADDR-1:0] rd;
        logic [OP_W-1:0]  op;
        logic             we;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               wr_ptr_q;
    logic               wr_ptr_d;
    logic               rd_ptr_q;
    logic               rd_ptr_d;
    logic [FLAG_W-1:0]  flags_d;

    logic               cond_pass;
    logic               push;
    logic               pop;
    entry_t             in_entry;
    entry_t             head;

    // Condition is judged against the flags held before the accepting edge.
    cond_check u_cond_check (
        .flags (flags_q),
        .cond  (cond),
        .pass  (cond_pass)
    );

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.result = resultado;
        in_entry.rd     = rd;
        in_entry.op     = operacion;
        in_entry.we     = cond_pass;
    end

    // Next state; flush wins over push, pop and any flag update.
    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = !wr_ptr_q;
                if (set_flags && cond_pass) begin
                    flags_d = flagsResult;
                end
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
        end
    end

    // Head presentation, zeroed while the buffer is empty.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_result = '0;
        out_rd     = '0;
        out_op     = '0;
        out_we     = 1'b0;
        if (out_valid) begin
            out_result = head.result;
            out_rd     = head.rd;
            out_op     = head.op;
            out_we     = head.we;
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst)
                                     !(push && (count_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
                                     !(pop && (count_q == '0)));
    a_count_range:  assert property (@(posedge clk) disable iff (!rst)
                                     (count_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: the driver models accepts and flags,
// the monitor compares every presented head word against the expected queue.
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RADDR = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] resultado;
    logic [3:0]       flagsResult;
    logic [3:0]       operacion;
    logic [RADDR-1:0] rd;
    logic             set_flags;
    logic [3:0]       cond;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic [RADDR-1:0] out_rd;
    logic [3:0]       out_op;
    logic             out_we;
    logic [3:0]       flags_q;

    int errors = 0;
    int checks = 0;

    // Expected words {result, rd, op, we}, oldest first.
    logic [WIDTH+RADDR+4:0] exp_q[$];
    logic [3:0]             mflags;
    bit                     mon_en;

    alu_wb_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .resultado   (resultado),
        .flagsResult (flagsResult),
        .operacion   (operacion),
        .rd          (rd),
        .set_flags   (set_flags),
        .cond        (cond),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_op      (out_op),
        .out_we      (out_we),
        .flags_q     (flags_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags are {S, Z, C, V} from bit 3 down to bit 0.
    function automatic bit cond_ref(input logic [3:0] f, input logic [3:0] c);
        bit v, cy, z, s;
        v  = f[0];
        cy = f[1];
        z  = f[2];
        s  = f[3];
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return s != v;
            4'd4:    return s == v;
            4'd5:    return cy;
            4'd6:    return !cy;
            4'd7:    return s;
            4'd8:    return !s;
            4'd9:    return v;
            4'd10:   return !v;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: check pre-edge state, drive, predict, advance past the edge.
    task automatic step(input bit iv, input logic [31:0] res, input logic [3:0] fl,
                        input logic [3:0] op, input logic [3:0] rdv, input bit sf,
                        input logic [3:0] cc, input bit fsh, input bit ordy);
        bit acc;
        bit ok;
        check("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
        check("flags_q", 64'(flags_q), 64'(mflags));
        in_valid    = iv;
        resultado   = res;
        flagsResult = fl;
        operacion   = op;
        rd          = rdv;
        set_flags   = sf;
        cond        = cc;
        flush       = fsh;
        out_ready   = ordy;
        acc = iv && (exp_q.size() != 2) && !fsh;
        ok  = cond_ref(mflags, cc);
        @(posedge clk);
        #1;
        if (fsh) exp_q.delete();
        else if (acc) exp_q.push_back({res, rdv, op, ok});
        if (acc && sf && ok) mflags = fl;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, OP_ADD, 4'd0, 1'b0, COND_AL, 1'b0, ordy);
    endtask

    // Reset pulse placed between clock edges; entered and left just after a rising edge.
    task automatic reset_mid();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_flags", 64'(flags_q), 64'd0);
        check("rst_out_zero", 64'({out_result, out_rd, out_op, out_we}), 64'd0);
        exp_q.delete();
        mflags = 4'd0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: compares the presented head at each falling edge, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() != 0) begin
                    check("out_valid", 64'(out_valid), 64'd1);
                    check("out_word", 64'({out_result, out_rd, out_op, out_we}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    check("out_valid_idle", 64'(out_valid), 64'd0);
                    check("out_idle_zero", 64'({out_result, out_rd, out_op, out_we}), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [3:0] fsave;
        rst = 1'b0;
        in_valid = 1'b0; resultado = '0; flagsResult = '0; operacion = '0; rd = '0;
        set_flags = 1'b0; cond = '0; flush = 1'b0; out_ready = 1'b0;
        mon_en = 1'b0;
        mflags = 4'd0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_flags", 64'(flags_q), 64'd0);
        check("reset_out_zero", 64'({out_result, out_rd, out_op, out_we}), 64'd0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // ADD 30, always, flags written as zero
        step(1'b1, 32'd30, 4'b0000, OP_ADD, 4'd1, 1'b1, COND_AL, 1'b0, 1'b1);
        check("s1_out_result", 64'(out_result), 64'd30);
        check("s1_out_we", 64'(out_we), 64'd1);
        idle(2, 1'b1);

        // SUB -20 sets S, then MI passes and EQ fails on the very next words
        step(1'b1, 32'hFFFF_FFEC, 4'b1000, OP_SUB, 4'd2, 1'b1, COND_AL, 1'b0, 1'b1);
        check("s2_flags", 64'(flags_q), 64'b1000);
        step(1'b1, 32'd11, 4'b0000, OP_MUL, 4'd3, 1'b0, COND_MI, 1'b0, 1'b1);
        step(1'b1, 32'd12, 4'b0000, OP_DIV, 4'd4, 1'b0, COND_EQ, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Back-pressure: 5, 6, 7 with out_ready low, then drain
        step(1'b1, 32'd5, 4'd0, OP_ADD, 4'd5, 1'b0, COND_AL, 1'b0, 1'b0);
        step(1'b1, 32'd6, 4'd0, OP_ADD, 4'd6, 1'b0, COND_AL, 1'b0, 1'b0);
        check("s3_in_ready_full", 64'(in_ready), 64'd0);
        step(1'b1, 32'd7, 4'd0, OP_ADD, 4'd7, 1'b0, COND_AL, 1'b0, 1'b0);
        step(1'b1, 32'd7, 4'd0, OP_ADD, 4'd7, 1'b0, COND_AL, 1'b0, 1'b1);
        step(1'b1, 32'd7, 4'd0, OP_ADD, 4'd7, 1'b0, COND_AL, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Flush a full buffer together with a flag-setting input
        step(1'b1, 32'd40, 4'd0, OP_MOD, 4'd8, 1'b0, COND_AL, 1'b0, 1'b0);
        step(1'b1, 32'd41, 4'd0, OP_MOD, 4'd9, 1'b0, COND_AL, 1'b0, 1'b0);
        fsave = flags_q;
        step(1'b1, 32'd99, 4'b1111, OP_ADD, 4'd10, 1'b1, COND_AL, 1'b1, 1'b0);
        check("s4_out_valid", 64'(out_valid), 64'd0);
        check("s4_in_ready", 64'(in_ready), 64'd1);
        check("s4_flags_kept", 64'(flags_q), 64'(fsave));
        idle(3, 1'b1);

        // Reset with one word buffered and Z set
        step(1'b1, 32'd55, 4'b0100, OP_ADD, 4'd11, 1'b1, COND_AL, 1'b0, 1'b0);
        check("s5_flags_pre", 64'(flags_q), 64'b0100);
        reset_mid();
        idle(3, 1'b1);

        // NE with Z set fails: flags hold, word stored with we=0
        step(1'b1, 32'd1, 4'b0100, OP_ADD, 4'd12, 1'b1, COND_AL, 1'b0, 1'b1);
        step(1'b1, 32'd2, 4'b1111, OP_SUB, 4'd13, 1'b1, COND_NE, 1'b0, 1'b1);
        check("s6_out_we", 64'(out_we), 64'd0);
        check("s6_flags_hold", 64'(flags_q), 64'b0100);
        idle(2, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_mid();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
            end
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of result.
REQ-002 Parameter RADDR, default 4: destination register index width.
REQ-003 The module SHALL have the following ports, in this order:

| Port | Dir | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | Single clock; all state rising-edge. |
| rst | in | 1 | Reset; asynchronous, active-low. |
| in_valid | in | 1 | Upstream ALU word valid. |
| in_ready | out | 1 | Stage can accept. |
| resultado | in | WIDTH | ALU result. |
| flagsResult | in | 4 | ALU flags: [0]=overflow V, [1]=carry C, [2]=zero Z, [3]=sign S. |
| operacion | in | 4 | ALU op code, carried through. |
| rd | in | RADDR | Destination register. |
| set_flags | in | 1 | Commit flagsResult to flag register. |
| cond | in | 4 | Execution condition code. |
| flush | in | 1 | Synchronous pipeline flush. |
| out_ready | in | 1 | Downstream (register file) can take. |
| out_valid | out | 1 | Head entry valid. |
| out_result | out | WIDTH | Head result. |
| out_rd | out | RADDR | Head destination. |
| out_op | out | 4 | Head op code. |
| out_we | out | 1 | Head write enable (condition passed). |
| flags_q | out | 4 | Committed flag register, same bit order as flagsResult. |

Function
REQ-004 Accept SHALL occur when in_valid && in_ready at the rising edge; pop SHALL occur when out_valid && out_ready.
REQ-005 Storage SHALL be a 2-entry in-order skid buffer with a count of 0..2; in_ready = (count != 2), combinational from registered count only.
REQ-006 Latency: a word accepted at edge N into an empty buffer SHALL present out_valid=1 after edge N; there is no combinational in->out path.
REQ-007 Simultaneous push and pop at count=1 SHALL leave count=1 and advance the head; at count=2 no push is possible.
REQ-008 Condition SHALL be evaluated at accept against flags_q as held before that edge:
- 0000 AL=1
- 0001 EQ=Z
- 0010 NE=!Z
- 0011 LT=S^V
- 0100 GE=!(S^V)
- 0101 CS=C
- 0110 CC=!C
- 0111 MI=S
- 1000 PL=!S
- 1001 VS=V
- 1010 VC=!V
- 1011..1111 NV=0
REQ-009 The stored out_we SHALL be the condition result; condition-failed words SHALL still enter the buffer (order preserved) with out_we=0.
REQ-010 On accept with set_flags=1 and condition pass, flags_q SHALL load flagsResult at that edge; otherwise flags_q SHALL hold.
REQ-011 Back-to-back dependency: a word accepted at edge N+1 SHALL see flags written at edge N.
REQ-012 flush=1 SHALL, at the next edge, set count=0 and discard any same-cycle input; flags_q SHALL be unaffected; in_ready SHALL be 1 the following cycle.
REQ-013 flush has priority over push and pop in the same cycle.
REQ-014 When out_valid=0, out_result/out_rd/out_op/out_we SHALL drive 0.
REQ-015 Pointers SHALL wrap modulo 2; overflow and underflow of count are unreachable and SHALL be asserted against in simulation.

Reset
REQ-016 rst=0 SHALL asynchronously clear count, pointers, entries and flags_q to 0, giving out_valid=0 and in_ready=1.
REQ-017 Reset asserted mid-operation SHALL drop all buffered words; none SHALL appear after release.
REQ-018 Reset release SHALL be synchronised by the integrator; the first accept is legal on the first edge after release.

Structure
REQ-019 A shared package SHALL hold the flag bit index constants (V=0, C=1, Z=2, S=3), the 4-bit condition-code enum and the ALU op code constants (ADD=0, SUB=1, MUL=2, DIV=3, MOD=4).
REQ-020 Condition evaluation SHALL be one combinational sub-module, cond_check (flags, cond -> pass).
REQ-021 Buffer entry SHALL be a packed struct {result, rd, op, we} defined locally.

Verification
REQ-022 Scenario 1: ADD with resultado=30, flags=0000, set_flags=1, cond=AL, out_ready=1 -> next cycle out_valid=1, out_result=30, out_we=1, flags_q=0000.
REQ-023 Scenario 2: SUB with resultado=-20 (0xFFFFFFEC), flags=1000, set_flags=1, then a word with cond=MI followed by a word with cond=EQ -> flags_q=1000, MI word out_we=1, EQ word out_we=0.
REQ-024 Scenario 3: out_ready=0 and three back-to-back words 5, 6, 7 -> in_ready=0 after two accepts; after releasing out_ready, outputs are 5, 6, 7 in order with no loss.
REQ-025 Scenario 4: buffer holding 2 words, flush=1 with in_valid=1 -> next cycle out_valid=0 and count=0, flags_q unchanged, the flushed input never appears.
REQ-026 Scenario 5: rst=0 asserted between clock edges with 1 word buffered and flags_q=0100 -> immediately out_valid=0 and flags_q=0000; after release, in_ready=1.
REQ-027 Scenario 6: set_flags=1 with cond=NE while flags_q Z=1 -> flags_q holds and the stored out_we=0.
